// File: rtl/hd_secded_pipe_if.sv
// Codeword-in / decoded-word-out bundle for the SECDED decoder pipeline.
// M and N are derived here the same way the decoder derives them.
interface hd_secded_pipe_if #(
    parameter int K     = 7,
    parameter int CNT_W = 16
);
    function automatic int calc_m(input int k);
        int m;
        m = 1;
        while ((1 << m) < (k + m + 1)) m++;
        return m;
    endfunction

    localparam int M = calc_m(K);
    localparam int N = K + M;

    logic [N:0]       cin;
    logic             cvld;
    logic             corr_en;
    logic             cnt_clr;
    logic [K-1:0]     dout;
    logic             dvld;
    logic             err_corr;
    logic             err_uncorr;
    logic [M-1:0]     syn;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    modport master (
        output cin, cvld, corr_en, cnt_clr,
        input  dout, dvld, err_corr, err_uncorr, syn, corr_cnt, uncorr_cnt
    );

    modport slave (
        input  cin, cvld, corr_en, cnt_clr,
        output dout, dvld, err_corr, err_uncorr, syn, corr_cnt, uncorr_cnt
    );
endinterface

// File: rtl/hd_secded_pipe.sv
// Two-stage pipelined SECDED Hamming decoder with optional correction,
// per-word error flags, syndrome output and saturating error counters.
module hd_secded_pipe #(
    parameter int K     = 7,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    hd_secded_pipe_if.slave  bus
);
    function automatic int calc_m(input int k);
        int m;
        m = 1;
        while ((1 << m) < (k + m + 1)) m++;
        return m;
    endfunction

    localparam int M = calc_m(K);
    localparam int N = K + M;
    localparam logic [N-1:0] ONE = N'(1);

    // Hamming position (1-based) holding data bit k.
    function automatic int data_pos(input int k);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 1; i <= N; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == k) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

    function automatic logic [N-1:0] syn_mask(input int j);
        logic [N-1:0] m;
        m = '0;
        for (int i = 1; i <= N; i++) begin
            if (((i >> j) & 1) != 0) m = m | (ONE << (i - 1));
        end
        return m;
    endfunction

    logic         s1_vld;
    logic         s1_corr_en;
    logic [N:0]   s1_cw;

    // Codeword only loads on valid, so an undriven cin never enters the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld     <= 1'b0;
            s1_corr_en <= 1'b0;
            s1_cw      <= '0;
        end else begin
            s1_vld <= bus.cvld;
            if (bus.cvld) begin
                s1_cw      <= bus.cin;
                s1_corr_en <= bus.corr_en;
            end
        end
    end

    logic [M-1:0] s;
    logic         p;
    logic         s_le_n;
    logic         single;
    logic         uncorr;
    logic         flip;
    logic [N-1:0] fix_cw;
    logic [K-1:0] data_out;

    for (genvar j = 0; j < M; j++) begin : g_syn
        localparam logic [N-1:0] SMASK = syn_mask(j);
        assign s[j] = ^(s1_cw[N-1:0] & SMASK);
    end

    assign p      = ^s1_cw;
    assign s_le_n = (int'(s) <= N);
    // S=0 with odd parity is an error in the overall-parity bit itself.
    assign single = p & s_le_n;
    assign uncorr = ((s != '0) & ~p) | (p & ~s_le_n);
    assign flip   = s1_corr_en & single & (s != '0);
    assign fix_cw = flip ? (s1_cw[N-1:0] ^ (ONE << (s - M'(1)))) : s1_cw[N-1:0];

    for (genvar g = 0; g < K; g++) begin : g_data
        localparam int DP = data_pos(g);
        assign data_out[g] = fix_cw[DP-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dvld       <= 1'b0;
            bus.err_corr   <= 1'b0;
            bus.err_uncorr <= 1'b0;
            bus.dout       <= '0;
            bus.syn        <= '0;
            bus.corr_cnt   <= '0;
            bus.uncorr_cnt <= '0;
        end else begin
            bus.dvld       <= s1_vld;
            bus.err_corr   <= s1_vld & single;
            bus.err_uncorr <= s1_vld & uncorr;
            if (s1_vld) begin
                bus.dout <= data_out;
                bus.syn  <= s;
            end
            if (bus.cnt_clr) begin
                bus.corr_cnt   <= '0;
                bus.uncorr_cnt <= '0;
            end else begin
                if (s1_vld && single && (bus.corr_cnt != '1))
                    bus.corr_cnt <= bus.corr_cnt + CNT_W'(1);
                if (s1_vld && uncorr && (bus.uncorr_cnt != '1))
                    bus.uncorr_cnt <= bus.uncorr_cnt + CNT_W'(1);
            end
        end
    end
endmodule
